// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one external 8-bit adder among three requesters.
// Operands are held on the adder for HOLD_CYCLES cycles before the sum is captured.
module add_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] opa,
    input  logic [23:0] opb,
    output logic [2:0]  gnt,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    input  logic [7:0]  add_s,
    output logic [7:0]  res,
    output logic        res_valid,
    output logic [1:0]  res_id,
    output logic        busy
);

    typedef enum logic {StIdle, StSettle} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [7:0]  add_a_q, add_a_d;
    logic [7:0]  add_b_q, add_b_d;
    logic [7:0]  res_q, res_d;
    logic        res_valid_q, res_valid_d;
    logic [1:0]  res_id_q, res_id_d;
    logic [1:0]  last_q, last_d;

    logic [1:0]  s0, s1, s2, pick;

    // Search order starts just after the last winner and wraps 2 -> 0.
    always_comb begin
        s0 = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        s1 = (s0 == 2'd2) ? 2'd0 : s0 + 2'd1;
        s2 = (s1 == 2'd2) ? 2'd0 : s1 + 2'd1;
        if (req[s0]) begin
            pick = s0;
        end else if (req[s1]) begin
            pick = s1;
        end else begin
            pick = s2;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = 3'b000;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        last_d      = last_q;
        unique case (state_q)
            StIdle: begin
                if (req != 3'b000) begin
                    gnt_d   = 3'b001 << pick;
                    add_a_d = opa[{pick, 3'b000} +: 8];
                    add_b_d = opb[{pick, 3'b000} +: 8];
                    cnt_d   = 4'(HOLD_CYCLES);
                    last_d  = pick;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res_d       = add_s;
                    res_id_d    = last_q;
                    res_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            gnt_q       <= 3'b000;
            add_a_q     <= 8'd0;
            add_b_q     <= 8'd0;
            res_q       <= 8'd0;
            res_valid_q <= 1'b0;
            res_id_q    <= 2'd0;
            last_q      <= 2'd2;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            last_q      <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q == StSettle);

endmodule

// File: tb/tb_add_arbiter.sv
// Directed checks of add_arbiter at HOLD_CYCLES=1 and HOLD_CYCLES=3.
module tb_add_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0]  req1, gnt1, req3, gnt3;
    logic [23:0] opa1, opb1, opa3, opb3;
    logic [7:0]  add_a1, add_b1, add_s1, res1, add_a3, add_b3, add_s3, res3;
    logic        rv1, busy1, rv3, busy3;
    logic [1:0]  rid1, rid3;

    // External shared adders
    assign add_s1 = add_a1 + add_b1;
    assign add_s3 = add_a3 + add_b3;

    add_arbiter #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .opa(opa1), .opb(opb1), .gnt(gnt1),
        .add_a(add_a1), .add_b(add_b1), .add_s(add_s1), .res(res1), .res_valid(rv1),
        .res_id(rid1), .busy(busy1)
    );

    add_arbiter #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .opa(opa3), .opb(opb3), .gnt(gnt3),
        .add_a(add_a3), .add_b(add_b3), .add_s(add_s3), .res(res3), .res_valid(rv3),
        .res_id(rid3), .busy(busy3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req1  = 3'b000;
        req3  = 3'b000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [2:0] exp_gnt_a [8] = '{3'b001, 3'b000, 3'b010, 3'b000,
                                  3'b100, 3'b000, 3'b001, 3'b000};
    logic [1:0] exp_rid_a [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0};
    logic [7:0] exp_res_a [8] = '{8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h33, 8'h00, 8'h11};
    logic [2:0] exp_gnt_b [8] = '{3'b001, 3'b000, 3'b100, 3'b000,
                                  3'b001, 3'b000, 3'b100, 3'b000};

    initial begin
        reset = 1'b1;
        req1 = '0; req3 = '0; opa1 = '0; opb1 = '0; opa3 = '0; opb3 = '0;
        #1;
        do_reset();

        check_eq("rst_gnt", gnt1, 3'b000);
        check_eq("rst_add_a", add_a1, 8'h00);
        check_eq("rst_add_b", add_b1, 8'h00);
        check_eq("rst_res", res1, 8'h00);
        check_eq("rst_valid", rv1, 1'b0);
        check_eq("rst_id", rid1, 2'd0);
        check_eq("rst_busy", busy1, 1'b0);

        // Requester 1: 0x25 + 0x1A
        req1 = 3'b010; opa1 = 24'h002500; opb1 = 24'h001A00;
        tick();
        check_eq("r1_gnt", gnt1, 3'b010);
        check_eq("r1_add_a", add_a1, 8'h25);
        check_eq("r1_add_b", add_b1, 8'h1A);
        check_eq("r1_busy", busy1, 1'b1);
        check_eq("r1_valid_early", rv1, 1'b0);
        req1 = 3'b000;
        tick();
        check_eq("r1_valid", rv1, 1'b1);
        check_eq("r1_res", res1, 8'h3F);
        check_eq("r1_id", rid1, 2'd1);
        check_eq("r1_gnt_clr", gnt1, 3'b000);
        check_eq("r1_busy_clr", busy1, 1'b0);
        tick();
        check_eq("r1_valid_pulse", rv1, 1'b0);
        check_eq("r1_res_hold", res1, 8'h3F);
        check_eq("r1_id_hold", rid1, 2'd1);

        // Requester 0 wraparound sums
        req1 = 3'b001; opa1 = 24'h0000F0; opb1 = 24'h000020;
        tick();
        check_eq("wrap1_gnt", gnt1, 3'b001);
        req1 = 3'b000;
        tick();
        check_eq("wrap1_valid", rv1, 1'b1);
        check_eq("wrap1_res", res1, 8'h10);
        check_eq("wrap1_id", rid1, 2'd0);
        req1 = 3'b001; opa1 = 24'h0000FF; opb1 = 24'h000001;
        tick();
        check_eq("wrap2_gnt", gnt1, 3'b001);
        check_eq("wrap2_valid_gap", rv1, 1'b0);
        req1 = 3'b000;
        tick();
        check_eq("wrap2_valid", rv1, 1'b1);
        check_eq("wrap2_res", res1, 8'h00);
        tick();

        // All three requesting continuously: back-to-back round robin
        do_reset();
        opa1 = 24'h030201; opb1 = 24'h302010; req1 = 3'b111;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("rr3_gnt_c%0d", i + 1), gnt1, exp_gnt_a[i]);
            check_eq($sformatf("rr3_valid_c%0d", i + 1), rv1, logic'(i % 2 == 1));
            check_eq($sformatf("rr3_busy_c%0d", i + 1), busy1, logic'(i % 2 == 0));
            if (i % 2 == 1) begin
                check_eq($sformatf("rr3_id_c%0d", i + 1), rid1, exp_rid_a[i]);
                check_eq($sformatf("rr3_res_c%0d", i + 1), res1, exp_res_a[i]);
            end
        end

        // Requesters 0 and 2 alternate; 1 never requests
        do_reset();
        req1 = 3'b101;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("rr2_gnt_c%0d", i + 1), gnt1, exp_gnt_b[i]);
        end

        // Reset during SETTLE aborts the add and restores priority to requester 0
        do_reset();
        req1 = 3'b010; opa1 = 24'h001100; opb1 = 24'h002200;
        tick();
        check_eq("abort_gnt", gnt1, 3'b010);
        check_eq("abort_busy", busy1, 1'b1);
        req1 = 3'b010;
        reset = 1'b1;
        tick();
        check_eq("abort_gnt_clr", gnt1, 3'b000);
        check_eq("abort_busy_clr", busy1, 1'b0);
        check_eq("abort_valid", rv1, 1'b0);
        check_eq("abort_add_a", add_a1, 8'h00);
        check_eq("abort_res", res1, 8'h00);
        reset = 1'b0;
        req1 = 3'b000;
        tick();
        check_eq("abort_no_valid", rv1, 1'b0);
        check_eq("abort_no_regrant", gnt1, 3'b000);
        req1 = 3'b111;
        tick();
        check_eq("abort_next_gnt", gnt1, 3'b001);
        req1 = 3'b000;
        tick();

        // HOLD_CYCLES=3: busy for three cycles, result on the fourth
        req3 = 3'b001; opa3 = 24'h000040; opb3 = 24'h000005;
        tick();
        check_eq("h3_gnt", gnt3, 3'b001);
        check_eq("h3_busy1", busy3, 1'b1);
        check_eq("h3_a1", add_a3, 8'h40);
        req3 = 3'b000;
        opa3 = 24'h0000AA; opb3 = 24'h0000BB;
        tick();
        check_eq("h3_gnt_clr", gnt3, 3'b000);
        check_eq("h3_busy2", busy3, 1'b1);
        check_eq("h3_a2", add_a3, 8'h40);
        check_eq("h3_b2", add_b3, 8'h05);
        check_eq("h3_valid2", rv3, 1'b0);
        tick();
        check_eq("h3_busy3", busy3, 1'b1);
        check_eq("h3_a3", add_a3, 8'h40);
        check_eq("h3_valid3", rv3, 1'b0);
        tick();
        check_eq("h3_busy4", busy3, 1'b0);
        check_eq("h3_valid4", rv3, 1'b1);
        check_eq("h3_res", res3, 8'h45);
        check_eq("h3_id", rid3, 2'd0);
        tick();
        check_eq("h3_valid5", rv3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
